// File: rtl/fft_sample_loader_if.sv
// Byte-stream input and frame-output bundle of the FFT sample loader.
// The slave modport is the loader's view; master is the view of whoever drives it.
interface fft_sample_loader_if #(
    parameter int DATA_W   = 8,
    parameter int N_POINTS = 4
);
    logic [DATA_W-1:0]              in_data;
    logic                           in_valid;
    logic                           in_sync;
    logic                           in_ready;
    logic [2*DATA_W*N_POINTS-1:0]   frame_out;
    logic                           frame_valid;
    logic                           frame_ready;
    logic                           err_overrun;
    logic                           err_clr;
    logic [7:0]                     frame_cnt;

    modport slave (
        input  in_data, in_valid, in_sync, frame_ready, err_clr,
        output in_ready, frame_out, frame_valid, err_overrun, frame_cnt
    );

    modport master (
        output in_data, in_valid, in_sync, frame_ready, err_clr,
        input  in_ready, frame_out, frame_valid, err_overrun, frame_cnt
    );
endinterface

// File: rtl/fft_sample_loader.sv
// Assembles N_POINTS complex samples from a byte stream and hands each frame,
// optionally bit-reversed, to the FFT core through a double-buffered valid/ready port.
module fft_sample_loader #(
    parameter int DATA_W      = 8,
    parameter int N_POINTS    = 4,
    parameter int BIT_REVERSE = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    fft_sample_loader_if.slave    bus
);
    localparam int SLOT_W  = 2 * DATA_W;
    localparam int FRAME_W = SLOT_W * N_POINTS;
    localparam int NBYTES  = 2 * N_POINTS;
    localparam int IDX_W   = $clog2(NBYTES);
    localparam int LOG_N   = $clog2(N_POINTS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [FRAME_W-1:0] fill_q, fill_d;
    logic               fill_full_q, fill_full_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic               frame_valid_q, frame_valid_d;
    logic               err_q, err_d;
    logic [7:0]         frame_cnt_q, frame_cnt_d;

    logic               in_ready_s;
    logic               accept_s;
    logic               consume_s;
    logic               last_s;
    logic [IDX_W-1:0]   wr_idx_s;

    // Output slot k takes input sample bitrev(k) (or k); pure wiring once elaborated.
    function automatic logic [FRAME_W-1:0] reorder(input logic [FRAME_W-1:0] f);
        logic [FRAME_W-1:0] r;
        int src;
        r = '0;
        for (int k = 0; k < N_POINTS; k++) begin
            src = 0;
            if (BIT_REVERSE != 0) begin
                for (int b = 0; b < LOG_N; b++) begin
                    src[LOG_N-1-b] = k[b];
                end
            end else begin
                src = k;
            end
            r[SLOT_W*k +: SLOT_W] = f[SLOT_W*src +: SLOT_W];
        end
        return r;
    endfunction

    // Next-state logic for byte capture, frame hand-off and status.
    always_comb begin
        in_ready_s    = !fill_full_q;
        accept_s      = bus.in_valid && in_ready_s;
        consume_s     = frame_valid_q && bus.frame_ready;
        wr_idx_s      = bus.in_sync ? '0 : idx_q;
        last_s        = accept_s && (wr_idx_s == LAST_IDX);
        fill_d        = fill_q;
        fill_full_d   = fill_full_q;
        frame_d       = frame_q;
        frame_valid_d = frame_valid_q;

        // Byte i of a frame lands at bit 8*i: slot i/2, real for even i, imag for odd.
        if (accept_s) begin
            fill_d[DATA_W*wr_idx_s +: DATA_W] = bus.in_data;
            idx_d = wr_idx_s + IDX_ONE;
        end else if (bus.in_sync) begin
            idx_d = '0;
        end else begin
            idx_d = idx_q;
        end

        if (last_s && (!frame_valid_q || consume_s)) begin
            frame_d       = reorder(fill_d);
            frame_valid_d = 1'b1;
        end else if (last_s) begin
            fill_full_d   = 1'b1;
        end else if (fill_full_q && consume_s) begin
            frame_d       = reorder(fill_q);
            fill_full_d   = 1'b0;
            frame_valid_d = 1'b1;
        end else if (consume_s) begin
            frame_valid_d = 1'b0;
        end else begin
            frame_valid_d = frame_valid_q;
        end

        // A new overrun outranks a simultaneous clear.
        if (bus.in_valid && !in_ready_s) begin
            err_d = 1'b1;
        end else if (bus.err_clr) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end

        frame_cnt_d = frame_cnt_q + (consume_s ? 8'd1 : 8'd0);
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q         <= '0;
            fill_q        <= '0;
            fill_full_q   <= 1'b0;
            frame_q       <= '0;
            frame_valid_q <= 1'b0;
            err_q         <= 1'b0;
            frame_cnt_q   <= 8'd0;
        end else begin
            idx_q         <= idx_d;
            fill_q        <= fill_d;
            fill_full_q   <= fill_full_d;
            frame_q       <= frame_d;
            frame_valid_q <= frame_valid_d;
            err_q         <= err_d;
            frame_cnt_q   <= frame_cnt_d;
        end
    end

    assign bus.in_ready    = !fill_full_q;
    assign bus.frame_out   = frame_q;
    assign bus.frame_valid = frame_valid_q;
    assign bus.err_overrun = err_q;
    assign bus.frame_cnt   = frame_cnt_q;
endmodule

// File: tb/tb_fft_sample_loader.sv
// Drives a bit-reversed and a natural-order loader with identical byte streams and
// checks both against a frame-queue reference model through a scoreboard.
module tb_fft_sample_loader;
    localparam int DW = 8;
    localparam int N  = 4;
    localparam int FW = 2 * DW * N;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fft_sample_loader_if #(.DATA_W(DW), .N_POINTS(N)) if_a ();
    fft_sample_loader_if #(.DATA_W(DW), .N_POINTS(N)) if_b ();

    fft_sample_loader #(.DATA_W(DW), .N_POINTS(N), .BIT_REVERSE(1)) dut_a (
        .clk(clk), .rst(rst), .bus(if_a));
    fft_sample_loader #(.DATA_W(DW), .N_POINTS(N), .BIT_REVERSE(0)) dut_b (
        .clk(clk), .rst(rst), .bus(if_b));

    int total = 0;
    int bad   = 0;

    // Reference model: frames completed but not yet consumed, plus the partial frame.
    int              occ;
    bit              m_err;
    int              m_cnt;
    int              m_idx;
    logic [7:0]      m_bytes [2*N];
    logic [FW-1:0]   sb_a [$];
    logic [FW-1:0]   sb_b [$];

    task automatic chk(input string nm, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic int bitrev(input int k);
        int r = 0;
        int x = k;
        for (int i = 0; i < $clog2(N); i++) begin
            r = r * 2 + (x % 2);
            x = x / 2;
        end
        return r;
    endfunction

    function automatic logic [FW-1:0] model_frame(input bit rev);
        logic [FW-1:0] f = '0;
        int src;
        for (int k = 0; k < N; k++) begin
            src = rev ? bitrev(k) : k;
            f[16*k +: 16] = {m_bytes[2*src+1], m_bytes[2*src]};
        end
        return f;
    endfunction

    task automatic model_reset();
        occ = 0; m_err = 0; m_cnt = 0; m_idx = 0;
        for (int i = 0; i < 2*N; i++) m_bytes[i] = 8'h00;
        sb_a.delete();
        sb_b.delete();
    endtask

    task automatic model_edge(input bit v, input bit s, input logic [7:0] d,
                              input bit fr, input bit clr);
        bit rdy  = (occ < 2);
        bit cons = (occ > 0) && fr;
        if (v && !rdy) m_err = 1;
        else if (clr)  m_err = 0;
        if (cons) begin
            occ--;
            m_cnt = (m_cnt + 1) % 256;
        end
        if (v && rdy) begin
            if (s) m_idx = 0;
            m_bytes[m_idx] = d;
            m_idx++;
            if (m_idx == 2*N) begin
                m_idx = 0;
                occ++;
                sb_a.push_back(model_frame(1'b1));
                sb_b.push_back(model_frame(1'b0));
            end
        end else if (s) begin
            m_idx = 0;
        end
    endtask

    task automatic drive(input bit v, input bit s, input logic [7:0] d,
                         input bit fr, input bit clr);
        if_a.in_valid = v;   if_b.in_valid = v;
        if_a.in_sync = s;    if_b.in_sync = s;
        if_a.in_data = d;    if_b.in_data = d;
        if_a.frame_ready = fr; if_b.frame_ready = fr;
        if_a.err_clr = clr;  if_b.err_clr = clr;
    endtask

    // Apply inputs for one edge, advance the model, return at posedge+1.
    task automatic step(input bit v, input bit s, input logic [7:0] d,
                        input bit fr, input bit clr);
        drive(v, s, d, fr, clr);
        @(posedge clk);
        if (!rst) model_edge(v, s, d, fr, clr);
        #1;
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic send_seq(input logic [7:0] first, input int n, input bit fr);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, first + 8'(i), fr, 1'b0);
    endtask

    // Monitor: status every cycle, frame contents popped from the scoreboard on handshakes.
    always @(negedge clk) begin
        logic [FW-1:0] e;
        chk("a_valid", FW'(if_a.frame_valid), FW'(occ > 0));
        chk("b_valid", FW'(if_b.frame_valid), FW'(occ > 0));
        chk("a_in_ready", FW'(if_a.in_ready), FW'(occ < 2));
        chk("b_in_ready", FW'(if_b.in_ready), FW'(occ < 2));
        chk("a_err", FW'(if_a.err_overrun), FW'(m_err));
        chk("b_err", FW'(if_b.err_overrun), FW'(m_err));
        chk("a_cnt", FW'(if_a.frame_cnt), FW'(m_cnt));
        chk("b_cnt", FW'(if_b.frame_cnt), FW'(m_cnt));
        if (!rst && if_a.frame_valid && if_a.frame_ready) begin
            if (sb_a.size() == 0) chk("a_unexpected_frame", FW'(1), FW'(0));
            else begin e = sb_a.pop_front(); chk("a_frame", if_a.frame_out, e); end
        end
        if (!rst && if_b.frame_valid && if_b.frame_ready) begin
            if (sb_b.size() == 0) chk("b_unexpected_frame", FW'(1), FW'(0));
            else begin e = sb_b.pop_front(); chk("b_frame", if_b.frame_out, e); end
        end
    end

    initial begin
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_frame_out", if_a.frame_out, '0);
        chk("rst_cnt", FW'(if_b.frame_cnt), FW'(0));

        // Basic frame, consumer always ready.
        send_seq(8'h01, 8, 1'b1);
        chk("nat_frame", if_b.frame_out, 64'h0807060504030201);
        chk("rev_frame", if_a.frame_out, 64'h0807040306050201);
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        chk("basic_cnt", FW'(if_a.frame_cnt), FW'(1));

        // Backpressure: both buffers fill, the 17th byte overruns.
        do_reset();
        send_seq(8'h01, 16, 1'b0);
        chk("bp_in_ready", FW'(if_a.in_ready), FW'(0));
        step(1'b1, 1'b0, 8'h11, 1'b0, 1'b0);
        chk("bp_overrun", FW'(if_a.err_overrun), FW'(1));
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        chk("bp_nat_second", if_b.frame_out, 64'h100F0E0D0C0B0A09);
        chk("bp_rev_second", if_a.frame_out, 64'h100F0C0B0E0D0A09);
        chk("bp_valid_kept", FW'(if_a.frame_valid), FW'(1));
        chk("bp_ready_back", FW'(if_a.in_ready), FW'(1));
        chk("bp_cnt", FW'(if_a.frame_cnt), FW'(1));
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        chk("bp_err_clr", FW'(if_b.err_overrun), FW'(0));

        // Resync mid-frame.
        do_reset();
        send_seq(8'h55, 3, 1'b1);
        step(1'b1, 1'b1, 8'hAA, 1'b1, 1'b0);
        send_seq(8'h01, 7, 1'b1);
        chk("sync_frame", if_b.frame_out, 64'h07060504030201AA);
        repeat (3) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        chk("sync_cnt", FW'(if_b.frame_cnt), FW'(1));

        // Reset mid-frame discards the partial frame.
        do_reset();
        send_seq(8'hE1, 5, 1'b1);
        do_reset();
        send_seq(8'h11, 8, 1'b1);
        chk("rst_mid_frame", if_b.frame_out, 64'h1817161514131211);
        repeat (3) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        chk("rst_mid_cnt", FW'(if_b.frame_cnt), FW'(1));

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 499) == 0) do_reset();
            else step($urandom_range(0, 9) < 7, $urandom_range(0, 99) < 3,
                      8'($urandom), $urandom_range(0, 1) == 1, $urandom_range(0, 19) == 0);
        end
        repeat (5) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        chk("drain_a", FW'(sb_a.size()), FW'(0));
        chk("drain_b", FW'(sb_b.size()), FW'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fft_sample_loader.md
Name: fft_sample_loader

Overview:
Input stage that sits directly upstream of the FFT butterfly core inside tt_um_FFT_engine. It takes the 8-bit byte stream arriving on ui_in, strobed by a valid bit, and assembles one frame of N_POINTS complex samples. It reorders the frame into bit-reversed index order for the radix-2 DIT core and presents it on a valid/ready interface. The block is double-buffered (fill register plus output register), so the next frame can load while the core holds the current one.

Parameters:
DATA_W, 8, width of each signed real/imag component.
N_POINTS, 4, complex samples per frame; power of two, 2..8.
BIT_REVERSE, 1, 1 = output slots in bit-reversed index order; 0 = natural order.

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst  input  1  asynchronous, active-high reset.
in_data  input  DATA_W  byte from pins; order per frame: s0_re, s0_im, s1_re, s1_im, ...
in_valid  input  1  in_data valid this cycle.
in_sync  input  1  start-of-frame marker; restarts byte index.
in_ready  output  1  loader can accept a byte this cycle.
frame_out  output  2*DATA_W*N_POINTS  slot k at [2*DATA_W*k +: 2*DATA_W]; real in low DATA_W bits, imag in high DATA_W bits.
frame_valid  output  1  frame_out holds a complete frame.
frame_ready  input  1  core consumes the frame when frame_valid && frame_ready.
err_overrun  output  1  sticky: a byte was offered while in_ready = 0.
err_clr  input  1  synchronous clear of err_overrun.
frame_cnt  output  8  count of frames handed to the core; wraps 255 -> 0.

Behaviour:
- Reset (async, any time, including mid-frame): byte index = 0, fill register = 0, fill_full = 0, frame_out = 0, frame_valid = 0, in_ready = 1, err_overrun = 0, frame_cnt = 0. A partial frame is discarded.
- Accept: a byte is accepted on an edge with in_valid && in_ready. It is written into fill slot (index/2); even index = real, odd index = imag. Index increments mod 2*N_POINTS.
- in_sync && in_valid && in_ready: the byte is stored as index 0 and index becomes 1; any partial frame is discarded.
- in_sync without an accepted byte: index is forced to 0.
- in_sync never discards a completed frame held in fill_full or the output register.
- Fill complete: on acceptance of byte 2*N_POINTS-1:
  - If the output register is empty, or is being consumed this edge (frame_valid && frame_ready), the frame moves to frame_out and frame_valid = 1 on the next cycle. Latency is 1 clock from the last-byte edge.
  - Otherwise fill_full = 1.
- in_ready = !fill_full (combinational from state).
- Transfer with fill_full: on the consume edge, the fill register moves to frame_out in the same edge. frame_valid stays 1 with no bubble, fill_full clears, and in_ready returns to 1 the following cycle.
- Consume with nothing pending: frame_valid drops to 0 next cycle; frame_out holds its last value.
- frame_cnt increments on each consume handshake.
- Reorder: output slot k = input sample bitrev(k, log2 N_POINTS) when BIT_REVERSE = 1, else sample k. The reorder is a fixed wiring permutation applied at transfer.
- err_overrun: set on any edge with in_valid && !in_ready; the byte is dropped and the index is unchanged. err_clr clears it. If set and clear coincide on the same edge, set wins.
- Samples are passed through as raw bits; no sign extension or arithmetic.

Test Plan:
- Reset, then check outputs: frame_valid = 0, in_ready = 1, frame_cnt = 0, err_overrun = 0, frame_out = 0.
- Natural order (BIT_REVERSE=0, N=4), bytes 0x01..0x08 on 8 consecutive cycles with frame_ready = 1 -> frame_valid high 1 cycle after the 8th edge, frame_out = 0x0807060504030201, then frame_cnt = 1.
- Bit-reversed order (default), same bytes -> frame_out = 0x0807040306050201 (slots s0, s2, s1, s3).
- Backpressure: frame_ready = 0, send 16 bytes 0x01..0x10 -> in_ready falls after the 16th accept; a 17th byte sets err_overrun and is dropped. Then raise frame_ready for one cycle -> frame_out switches to the second frame (0x10..0x09 pattern) with frame_valid continuous, in_ready = 1 next cycle, frame_cnt = 1.
- Resync: send 3 bytes, then in_sync with byte 0xAA, then 7 more bytes 0x01..0x07 -> frame slot0 real = 0xAA, no stale data, exactly one frame produced.
- Reset mid-frame: after 5 bytes assert rst for 1 cycle, then send 8 fresh bytes -> exactly one frame with only the fresh bytes, frame_cnt = 1.
